// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester A/B handshakes and DataMemory port bundle
interface dm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic          a_rready;
  logic [DW-1:0] a_rdata;
  logic          a_err;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic          b_rready;
  logic [DW-1:0] b_rdata;
  logic          b_err;

  logic [AW-1:0] DMaddr;
  logic [DW-1:0] DMin;
  logic          DMwr;
  logic [DW-1:0] DMout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_rready,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_we, b_addr, b_wdata, b_rready,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output DMaddr, DMin, DMwr,
    input  DMout
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_rready,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_we, b_addr, b_wdata, b_rready,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  DMaddr, DMin, DMwr,
    output DMout
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin two-requester sequencer for single-port DataMemory
module dm_arbiter #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic          OWN_A     = 1'b0;
  localparam logic          OWN_B     = 1'b1;
  localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          pick_b;
  logic          gnt_a, gnt_b;
  logic [AW-1:0] win_addr;
  logic          a_own, b_own;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    pick_b   = 1'b0;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    win_addr = '0;

    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          // On a tie the requester served least recently goes first.
          pick_b   = bus.b_req && (!bus.a_req || last_q == OWN_A);
          gnt_a    = !pick_b;
          gnt_b    = pick_b;
          win_addr = pick_b ? bus.b_addr : bus.a_addr;
          owner_d  = pick_b ? OWN_B : OWN_A;
          we_d     = pick_b ? bus.b_we : bus.a_we;
          addr_d   = win_addr;
          wdata_d  = pick_b ? bus.b_wdata : bus.a_wdata;
          err_d    = (win_addr >= DEPTH_LIM);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (!we_q && !err_q) ? bus.DMout : '0;
        state_d = RESP;
      end
      RESP: begin
        if ((owner_q == OWN_A) ? bus.a_rready : bus.b_rready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      last_q  <= OWN_B;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // addr_q/wdata_q only change on the grant edge, so they double as the held memory bus.
  assign bus.DMaddr = addr_q;
  assign bus.DMin   = wdata_q;
  assign bus.DMwr   = (state_q == ACCESS) && we_q && !err_q && rst;

  assign bus.a_gnt = gnt_a && rst;
  assign bus.b_gnt = gnt_b && rst;

  assign a_own = (state_q == RESP) && (owner_q == OWN_A);
  assign b_own = (state_q == RESP) && (owner_q == OWN_B);

  assign bus.a_rvalid = a_own;
  assign bus.a_rdata  = a_own ? rdata_q : '0;
  assign bus.a_err    = a_own && err_q;
  assign bus.b_rvalid = b_own;
  assign bus.b_rdata  = b_own ? rdata_q : '0;
  assign bus.b_err    = b_own && err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter
module tb_dm_arbiter;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  always #5 clk = ~clk;

  dm_arbiter_if #(.AW(32), .DW(32)) bus ();

  dm_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          last_b;
  int          passed = 0;
  int          total  = 0;

  assign bus.DMout = (bus.DMaddr < 32'(DEPTH)) ? mem[bus.DMaddr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (bus.DMwr && bus.DMaddr < 32'(DEPTH)) begin
      mem[bus.DMaddr[9:0]] <= bus.DMin;
    end
  end

  typedef struct {
    bit          who;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic gnt_of(input bit who);
    return who ? bus.b_gnt : bus.a_gnt;
  endfunction
  function automatic logic rvalid_of(input bit who);
    return who ? bus.b_rvalid : bus.a_rvalid;
  endfunction
  function automatic logic [31:0] rdata_of(input bit who);
    return who ? bus.b_rdata : bus.a_rdata;
  endfunction
  function automatic logic err_of(input bit who);
    return who ? bus.b_err : bus.a_err;
  endfunction

  task automatic drive(input bit who, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (who) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  task automatic set_rready(input bit who, input bit v);
    if (who) bus.b_rready = v;
    else     bus.a_rready = v;
  endtask

  // Called at a negedge in IDLE with the requester's inputs already driven.
  task automatic serve(input bit who, input int dly,
                       output logic [31:0] got_rdata, output logic got_err);
    bit          g;
    int          w;
    logic        we, exp_err;
    logic [31:0] addr, wdata, exp_rd;
    g = 0;
    got_rdata = 32'h0;
    got_err   = 1'b0;
    for (w = 0; w < 20; w++) begin
      #1;
      if (gnt_of(who)) begin g = 1; break; end
      @(negedge clk);
    end
    chk("gnt_seen", 32'(g), 32'd1);
    if (!g) return;
    chk("gnt_wait", w, 0);
    chk("gnt_other", 32'(gnt_of(!who)), 32'd0);
    we      = who ? bus.b_we    : bus.a_we;
    addr    = who ? bus.b_addr  : bus.a_addr;
    wdata   = who ? bus.b_wdata : bus.a_wdata;
    exp_err = (addr >= 32'(DEPTH));
    exp_rd  = (we || exp_err) ? 32'h0 : ref_mem[addr[9:0]];

    @(negedge clk);
    drive(who, 1'b0, 1'($urandom), $urandom, $urandom);
    #1;
    chk("dm_wr", 32'(bus.DMwr), 32'(we && !exp_err));
    if (we && !exp_err) begin
      chk("dm_addr", bus.DMaddr, addr);
      chk("dm_din", bus.DMin, wdata);
      ref_mem[addr[9:0]] = wdata;
    end
    chk("gnt_in_access", 32'(bus.a_gnt | bus.b_gnt), 32'd0);
    chk("rvalid_in_access", 32'(bus.a_rvalid | bus.b_rvalid), 32'd0);

    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      set_rready(who, i == dly);
      #1;
      chk("rvalid", 32'(rvalid_of(who)), 32'd1);
      chk("rdata", rdata_of(who), exp_rd);
      chk("err", 32'(err_of(who)), 32'(exp_err));
      chk("rvalid_other", 32'(rvalid_of(!who)), 32'd0);
      chk("gnt_in_resp", 32'(bus.a_gnt | bus.b_gnt), 32'd0);
      chk("dmwr_in_resp", 32'(bus.DMwr), 32'd0);
      got_rdata = rdata_of(who);
      got_err   = err_of(who);
    end
    last_b = who;
    @(negedge clk);
    set_rready(who, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'(DEPTH) + $urandom_range(0, 7);
    if (r == 1) return 32'hFFFF_FFF0;
    return $urandom_range(0, 31);
  endfunction

  logic [31:0] rd;
  logic        er;
  bit          first;

  initial begin
    rst = 1'b0;
    init_mem = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    drive(0, 1'b1, 1'b1, 32'd5, 32'h55);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.a_rready = 1'b0;
    bus.b_rready = 1'b0;
    last_b = 1;

    // Reset held for two cycles with A requesting a write.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
      chk("rst_dmwr", 32'(bus.DMwr), 32'd0);
      if (c == 1) begin
        chk("rst_dmaddr", bus.DMaddr, 32'd0);
        chk("rst_dmin", bus.DMin, 32'd0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        chk("rst_a_rdata", bus.a_rdata, 32'd0);
        chk("rst_b_err", 32'(bus.b_err), 32'd0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    init_mem = 1'b0;
    serve(0, 0, rd, er);

    vecs.push_back('{0, 1, 32'd15,   32'h1234_5678, 0, 32'h0,          0});
    vecs.push_back('{0, 0, 32'd15,   32'h0,         0, 32'h1234_5678,  0});
    vecs.push_back('{1, 1, 32'd1024, 32'hDEAD_BEEF, 0, 32'h0,          1});
    vecs.push_back('{1, 0, 32'd1023, 32'h0,         1, 32'h0,          0});
    vecs.push_back('{0, 1, 32'd1023, 32'hCAFE_F00D, 0, 32'h0,          0});
    vecs.push_back('{1, 0, 32'd1023, 32'h0,         2, 32'hCAFE_F00D,  0});
    vecs.push_back('{1, 0, 32'd1024, 32'h0,         0, 32'h0,          1});
    vecs.push_back('{0, 0, 32'hFFFF_FFFF, 32'h0,    0, 32'h0,          1});
    vecs.push_back('{0, 0, 32'd5,    32'h0,         0, 32'h55,         0});
    foreach (vecs[k]) begin
      drive(vecs[k].who, 1'b1, vecs[k].we, vecs[k].addr, vecs[k].wdata);
      serve(vecs[k].who, vecs[k].dly, rd, er);
      chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
      chk($sformatf("vec%0d_err", k), 32'(er), 32'(vecs[k].exp_err));
    end

    // Tie: both held, last owner was A so B goes first, then strict alternation.
    drive(0, 1'b1, 1'b1, 32'd20, 32'hAAAA_0001);
    drive(1, 1'b1, 1'b1, 32'd21, 32'hBBBB_0002);
    serve(1, 0, rd, er);
    drive(1, 1'b1, 1'b0, 32'd20, 32'h0);
    serve(0, 0, rd, er);
    drive(0, 1'b1, 1'b0, 32'd21, 32'h0);
    serve(1, 0, rd, er);
    chk("tie_b_reads_a", rd, 32'hAAAA_0001);
    serve(0, 0, rd, er);
    chk("tie_a_reads_b", rd, 32'hBBBB_0002);

    // Backpressure: B holds RESP for 5 cycles while A keeps requesting.
    drive(1, 1'b1, 1'b0, 32'd15, 32'h0);
    drive(0, 1'b1, 1'b0, 32'd1023, 32'h0);
    serve(1, 5, rd, er);
    chk("bp_b_rdata", rd, 32'h1234_5678);
    serve(0, 0, rd, er);
    chk("bp_a_rdata", rd, 32'hCAFE_F00D);

    // Reset during the ACCESS cycle of an A write.
    drive(0, 1'b1, 1'b1, 32'd15, 32'h0BAD_0BAD);
    #1;
    chk("midrst_gnt", 32'(bus.a_gnt), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_dmwr", 32'(bus.DMwr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_b = 1;
    #1;
    chk("midrst_rvalid0", 32'(bus.a_rvalid), 32'd0);
    chk("midrst_mem", mem[15], 32'h1234_5678);
    @(negedge clk);
    #1;
    chk("midrst_rvalid1", 32'(bus.a_rvalid), 32'd0);
    drive(0, 1'b1, 1'b0, 32'd15, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd1023, 32'h0);
    serve(0, 0, rd, er);
    chk("midrst_read", rd, 32'h1234_5678);
    serve(1, 0, rd, er);

    // Random traffic against the reference memory and round-robin model.
    for (int it = 0; it < 40; it++) begin
      int p;
      p = $urandom_range(1, 3);
      if (p == 1 || p == 3) drive(0, 1'b1, 1'($urandom), rand_addr(), $urandom);
      if (p == 2 || p == 3) drive(1, 1'b1, 1'($urandom), rand_addr(), $urandom);
      if (p == 3) begin
        first = !last_b;
        serve(first, $urandom_range(0, 2), rd, er);
        serve(!first, $urandom_range(0, 2), rd, er);
      end else begin
        serve(p == 2, $urandom_range(0, 2), rd, er);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port DataMemory (ports DMaddr, DMin, DMwr, DMout).
- Requester A is the CPU load/store stage. Requester B is the program/data loader or debug port.
- Grants one transaction at a time using round-robin, drives the memory for exactly one cycle, and returns the read data and status through a valid/ready response handshake.
- Sits between the datapath MEM stage and DataMemory in the multicycle and pipelined CPUs.

Parameters:
- DEPTH, 1024: number of valid DataMemory addresses; any address >= DEPTH is out of range.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- a_req  in  1  A requests a transaction.
- a_we  in  1  A transaction is a write (1) or a read (0).
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  A request accepted this cycle.
- a_rvalid  out  1  A response valid.
- a_rready  in  1  A accepts the response.
- a_rdata  out  DW  A read data.
- a_err  out  1  A address was out of range.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rready, b_rdata, b_err: same as the A ports, for requester B.
- DMaddr  out  AW  to DataMemory.
- DMin  out  DW  to DataMemory.
- DMwr  out  1  DataMemory write enable.
- DMout  in  DW  from DataMemory; combinational read of DMaddr.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Internal registers: owner (A/B), last (A/B), we_q, addr_q, wdata_q, rdata_q, err_q.
- Reset (rst=0 at a rising edge) gives:
  - state=IDLE, last=B, all _q registers 0.
  - All outputs 0, including DMaddr, DMin and DMwr.
- DMwr is additionally gated combinationally by rst: it is 0 in any cycle where rst=0, so no memory write ever happens during reset.
- Reset mid-transaction abandons the transaction. No response is issued and the requester must re-request.
- IDLE:
  - If only one requester has req=1, that requester wins.
  - If both have req=1, the requester that is not `last` wins (round-robin). After reset A wins the first tie.
  - The winner's gnt=1 combinationally in that cycle; the loser's gnt=0.
  - At the edge: owner=winner; we_q, addr_q and wdata_q capture the winner's inputs; err_q=(addr>=DEPTH); state goes to ACCESS.
  - With no req, the block stays in IDLE.
- gnt is asserted only in IDLE. A requester must hold req, we, addr and wdata stable until it sees gnt. These inputs are sampled only in the gnt cycle.
- ACCESS (exactly 1 cycle):
  - DMaddr=addr_q, DMin=wdata_q, DMwr=we_q & ~err_q.
  - At the edge: rdata_q = (~we_q & ~err_q) ? DMout : 0; state goes to RESP.
  - Outside ACCESS, DMwr=0 and DMaddr/DMin hold their last driven values.
- RESP:
  - The owner's rvalid=1, rdata=rdata_q, err=err_q.
  - The non-owner's rvalid, rdata and err are 0.
  - When the owner's rready=1, the handshake completes at that edge: last=owner, state goes to IDLE.
  - Otherwise the block stays in RESP with the response held stable.
- Latency and throughput:
  - gnt in cycle N, memory access in N+1, rvalid from N+2.
  - Minimum 3 cycles per transaction. At most one transaction is outstanding.
- Out-of-range access: no memory write; read data returned as 0; err=1. Arbitration is unaffected.
- A requester whose req drops before gnt is never granted. A req held across another requester's transaction is served next by round-robin.
- A write response has rdata=0; rvalid marks write completion.

Test Plan:
- Reset: hold rst=0 for 2 cycles with a_req=1 and a_we=1 -> gnt=0, DMwr=0 every cycle, all outputs 0. Release reset -> a_gnt=1 in the first IDLE cycle.
- Single write/read by A:
  - Write addr 15, data 32'h12345678 -> DMwr=1 only in the cycle after a_gnt, with DMaddr=15 and DMin=32'h12345678; a_rvalid=1 two cycles after gnt.
  - Then read addr 15 -> a_rdata=32'h12345678, a_err=0.
- Tie arbitration: a_req and b_req held high for 4 transactions with rready=1 -> grants alternate A, B, A, B; each rvalid goes only to the granted owner.
- Backpressure: b_rready=0 for 5 cycles during RESP -> b_rvalid and b_rdata stay stable, a_gnt stays 0 despite a_req=1. Raise b_rready -> A is granted in the following IDLE cycle.
- Out of range: B writes addr DEPTH (1024) -> DMwr stays 0, b_err=1, b_rdata=0. A subsequent read of addr 1023 is unaffected.
- Reset mid-op: assert rst=0 during ACCESS of an A write -> DMwr=0 in that cycle, memory word unchanged, no a_rvalid; state returns to IDLE.
